sort_arbiter: RTL and testbench
===============================

Name: sort_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one insert_sort datapath instance among NREQ requesters.
- Latches the granted requester's vector and drives the sorter's start/data.
- Waits for done, error or timeout, then returns the sorted values, positions and status to the owner over a valid/ready response handshake.
- Sits between the requesting engines and the single sorter instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- INPUTVALS, 16, values per vector; must match the sorter.
- INPUTBITWIDTHS, 32, bits per value; must match the sorter.
- TIMEOUT, 1024, max cycles waiting for srt_done before declaring a timeout (>= 4).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NREQ  per-requester request level; held high until its response is accepted.
- req_data  in  NREQ*INPUTVALS*INPUTBITWIDTHS  per-requester vector; requester i occupies slice i.
- gnt  out  NREQ  one-hot owner; high from grant until response accepted.
- rsp_valid  out  NREQ  one-hot; response available to requester i.
- rsp_ready  in  NREQ  per-requester accept.
- rsp_sorted  out  INPUTVALS*INPUTBITWIDTHS  sorted values, shared bus, valid with rsp_valid.
- rsp_positions  out  INPUTVALS*($clog2(INPUTVALS)+1)  sorted source positions, shared bus.
- rsp_status  out  2  00 ok, 01 sorter error, 10 timeout.
- srt_start  out  1  one-cycle start pulse to the sorter.
- srt_data  out  INPUTVALS*INPUTBITWIDTHS  registered vector to the sorter's needs_sorting.
- srt_done  in  1  sorter sortdone.
- srt_sorted  in  INPUTVALS*INPUTBITWIDTHS  sorter sorted output.
- srt_positions  in  INPUTVALS*($clog2(INPUTVALS)+1)  sorter sorted_positions.
- srt_error  in  1  sorter error flag.

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE; gnt, rsp_valid, srt_start, srt_data, rsp_sorted, rsp_positions, rsp_status all 0;
  - rr pointer 0; timeout counter 0.
  - Reset mid-operation abandons the job silently; no response is issued.
- All outputs are registered.
- States:
  - IDLE: if any req, select the first set req scanning from index ptr upward, wrapping mod NREQ. At that edge set gnt[i], load srt_data from slice i, go LAUNCH.
  - LAUNCH: srt_start=1 for exactly this one cycle; clear the counter; go WAIT.
  - WAIT: counter increments each cycle.
    - srt_error=1: capture rsp_status=01, zero the result buses, go RESPOND.
    - Else srt_done=1: capture srt_sorted/srt_positions, status 00, go RESPOND.
    - Else counter == TIMEOUT-1: status 10, zero the result buses, go RESPOND.
    - Precedence: error > done > timeout.
  - RESPOND: rsp_valid[owner]=1, result buses held stable.
    - On an edge with rsp_ready[owner]=1: clear rsp_valid and gnt, set ptr=(owner+1) mod NREQ, go IDLE.
    - rsp_ready of non-owners is ignored.
  - Any unencoded state: treat as IDLE with all outputs cleared.
- Minimum turnaround: req high at edge 0 gives gnt at edge 0; srt_start in cycle 1; sorter latency L; rsp_valid after done + 1 edge. Next grant occurs no earlier than the edge after acceptance (one IDLE cycle between jobs).
- Fairness: a continuously requesting requester is granted within NREQ jobs.
- req deasserted after grant: the job still completes and the response is still presented. A new req from the same index is not considered until IDLE.
- srt_done or srt_error outside WAIT: ignored.
- srt_data is held constant from grant until the next grant.
- Timeout counter width: $clog2(TIMEOUT)+1, no wrap inside WAIT.

Test Plan:
- Single request: NREQ=4, req=0001, vector {3,1,2,0,...}, model sorter done after 40 cycles. Require one srt_start pulse, gnt=0001, rsp_status=00, rsp_sorted ascending, rsp_valid held until rsp_ready.
- Round-robin: req=1111 held continuously. Require grant order 0,1,2,3,0, with exactly one gnt bit per job and no overlapping jobs.
- Backpressure: rsp_ready low for 20 cycles in RESPOND. Require rsp_valid and buses stable, no new grant, and a grant to the next requester one edge after acceptance.
- Error and timeout:
  - srt_error and srt_done in the same WAIT cycle → status 01, result buses zero.
  - Sorter silent with TIMEOUT=16 → status 10 exactly 16 cycles after srt_start.
- Reset mid-WAIT: reset low for 2 cycles. Require all outputs 0 immediately (asynchronous) and ptr=0; on release, a pending req=0100 is granted gnt=0100.
- Spurious srt_done in IDLE with no req: no state change, outputs remain 0.

Source files
------------

// File: rtl/sort_arbiter.sv
// sort_arbiter: round-robin arbiter that shares one sorter among NREQ requesters,
// launching each granted job and returning its result over a valid/ready response.
module sort_arbiter #(
    parameter int NREQ           = 4,
    parameter int INPUTVALS      = 16,
    parameter int INPUTBITWIDTHS = 32,
    parameter int TIMEOUT        = 1024
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NREQ-1:0]                               req,
    input  logic [NREQ*INPUTVALS*INPUTBITWIDTHS-1:0]      req_data,
    output logic [NREQ-1:0]                               gnt,
    output logic [NREQ-1:0]                               rsp_valid,
    input  logic [NREQ-1:0]                               rsp_ready,
    output logic [INPUTVALS*INPUTBITWIDTHS-1:0]           rsp_sorted,
    output logic [INPUTVALS*($clog2(INPUTVALS)+1)-1:0]    rsp_positions,
    output logic [1:0]                                    rsp_status,
    output logic                                          srt_start,
    output logic [INPUTVALS*INPUTBITWIDTHS-1:0]           srt_data,
    input  logic                                          srt_done,
    input  logic [INPUTVALS*INPUTBITWIDTHS-1:0]           srt_sorted,
    input  logic [INPUTVALS*($clog2(INPUTVALS)+1)-1:0]    srt_positions,
    input  logic                                          srt_error
);
    localparam int W  = INPUTVALS*INPUTBITWIDTHS;
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT)+1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    logic [1:0]    state;
    logic [IW-1:0] ptr, owner, sel;
    logic [CW-1:0] cnt;

    // Descending scan so the last hit, i.e. the closest index at or after ptr, wins.
    always_comb begin
        sel = ptr;
        for (int k = NREQ-1; k >= 0; k--)
            if (req[(int'(ptr) + k) % NREQ]) sel = IW'((int'(ptr) + k) % NREQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            gnt           <= '0;
            rsp_valid     <= '0;
            srt_start     <= 1'b0;
            srt_data      <= '0;
            rsp_sorted    <= '0;
            rsp_positions <= '0;
            rsp_status    <= 2'b00;
            ptr           <= '0;
            owner         <= '0;
            cnt           <= '0;
        end else begin
            srt_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt       <= NREQ'(1) << sel;
                        owner     <= sel;
                        srt_data  <= req_data[int'(sel)*W +: W];
                        srt_start <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (srt_error || srt_done || cnt == CW'(TIMEOUT-1)) begin
                        rsp_valid     <= gnt;
                        rsp_status    <= srt_error ? 2'b01 : srt_done ? 2'b00 : 2'b10;
                        rsp_sorted    <= (!srt_error && srt_done) ? srt_sorted : '0;
                        rsp_positions <= (!srt_error && srt_done) ? srt_positions : '0;
                        state         <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= '0;
                        gnt       <= '0;
                        ptr       <= IW'((int'(owner) + 1) % NREQ);
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    gnt           <= '0;
                    rsp_valid     <= '0;
                    srt_data      <= '0;
                    rsp_sorted    <= '0;
                    rsp_positions <= '0;
                    rsp_status    <= 2'b00;
                    cnt           <= '0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort_arbiter.sv
// tb_sort_arbiter: directed and randomized jobs against a round-robin/sort reference;
// a second instance with TIMEOUT=16 and a silent sorter covers the timeout path.
module tb_sort_arbiter;
    localparam int N  = 4;
    localparam int V  = 16;
    localparam int B  = 32;
    localparam int PW = $clog2(V)+1;
    localparam int W  = V*B;
    localparam int PT = V*PW;
    localparam int TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  req, rsp_ready, gnt, rsp_valid;
    logic [N*W-1:0] req_data;
    logic [W-1:0]  rsp_sorted, srt_data, srt_sorted;
    logic [PT-1:0] rsp_positions, srt_positions;
    logic [1:0]    rsp_status;
    logic          srt_start, srt_done, srt_error;

    logic [N-1:0]  req_t, rsp_ready_t, gnt_t, rsp_valid_t;
    logic [W-1:0]  rsp_sorted_t, srt_data_t;
    logic [PT-1:0] rsp_positions_t;
    logic [1:0]    rsp_status_t;
    logic          srt_start_t;

    int errors = 0;
    int checks = 0;
    int rr     = 0;

    sort_arbiter #(.NREQ(N), .INPUTVALS(V), .INPUTBITWIDTHS(B), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sorted(rsp_sorted),
        .rsp_positions(rsp_positions), .rsp_status(rsp_status), .srt_start(srt_start),
        .srt_data(srt_data), .srt_done(srt_done), .srt_sorted(srt_sorted),
        .srt_positions(srt_positions), .srt_error(srt_error)
    );

    sort_arbiter #(.NREQ(N), .INPUTVALS(V), .INPUTBITWIDTHS(B), .TIMEOUT(TO)) dut_to (
        .clk(clk), .reset(reset), .req(req_t), .req_data(req_data), .gnt(gnt_t),
        .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t), .rsp_sorted(rsp_sorted_t),
        .rsp_positions(rsp_positions_t), .rsp_status(rsp_status_t), .srt_start(srt_start_t),
        .srt_data(srt_data_t), .srt_done(1'b0), .srt_sorted({W{1'b1}}),
        .srt_positions({PT{1'b1}}), .srt_error(1'b0)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // Stable ascending sort of the vector, with each value's original index.
    function automatic void ref_sort(input logic [W-1:0] v, output logic [W-1:0] s, output logic [PT-1:0] p);
        int unsigned val[V];
        int pos[V];
        int unsigned tv;
        int tp;
        for (int i = 0; i < V; i++) begin
            val[i] = v[i*B +: B];
            pos[i] = i;
        end
        for (int i = 1; i < V; i++)
            for (int j = i; j > 0 && val[j-1] > val[j]; j--) begin
                tv = val[j]; val[j] = val[j-1]; val[j-1] = tv;
                tp = pos[j]; pos[j] = pos[j-1]; pos[j-1] = tp;
            end
        for (int i = 0; i < V; i++) begin
            s[i*B +: B]  = val[i];
            p[i*PW +: PW] = PW'(pos[i]);
        end
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_gnt"}, W'(gnt), '0);
        chk({tag, "_rsp_valid"}, W'(rsp_valid), '0);
        chk({tag, "_srt_start"}, W'(srt_start), '0);
        chk({tag, "_srt_data"}, srt_data, '0);
        chk({tag, "_rsp_sorted"}, rsp_sorted, '0);
        chk({tag, "_rsp_positions"}, W'(rsp_positions), '0);
        chk({tag, "_rsp_status"}, W'(rsp_status), '0);
    endtask

    task automatic job(input int lat, input bit err, input int hold, input bit drop,
                       input logic [N-1:0] next_req, input int exp_wait);
        int own, n;
        logic [N-1:0] eg;
        logic [W-1:0] vec, es;
        logic [PT-1:0] ep;
        own = pick(req, rr);
        eg  = N'(1) << own;
        vec = req_data[own*W +: W];
        n = 0;
        while (gnt === '0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("grant", W'(gnt), W'(eg));
        if (exp_wait >= 0) chk("grant_latency", W'(n), W'(exp_wait));
        chk("srt_start_high", W'(srt_start), W'(1));
        chk("srt_data", srt_data, vec);
        if (drop) req[own] = 1'b0;
        @(negedge clk);
        chk("srt_start_pulse", W'(srt_start), '0);
        repeat (lat - 1) begin
            @(negedge clk);
            chk("no_early_rsp", W'(rsp_valid), '0);
        end
        ref_sort(vec, es, ep);
        srt_done = 1'b1;
        srt_error = err;
        srt_sorted = es;
        srt_positions = ep;
        @(negedge clk);
        srt_done = 1'b0;
        srt_error = 1'b0;
        srt_sorted = ~es;
        srt_positions = ~ep;
        if (err) begin
            es = '0;
            ep = '0;
        end
        chk("rsp_valid", W'(rsp_valid), W'(eg));
        chk("rsp_status", W'(rsp_status), err ? W'(1) : W'(0));
        chk("rsp_sorted", rsp_sorted, es);
        chk("rsp_positions", W'(rsp_positions), W'(ep));
        for (int h = 0; h < hold; h++) begin
            rsp_ready = ~eg;
            @(negedge clk);
            chk("hold_valid", W'(rsp_valid), W'(eg));
            chk("hold_gnt", W'(gnt), W'(eg));
            chk("hold_sorted", rsp_sorted, es);
            chk("hold_status", W'(rsp_status), err ? W'(1) : W'(0));
        end
        rsp_ready = eg;
        @(negedge clk);
        rsp_ready = '0;
        req = next_req;
        chk("accept_valid", W'(rsp_valid), '0);
        chk("accept_gnt", W'(gnt), '0);
        rr = (own + 1) % N;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [N-1:0] m;
        reset = 1'b0;
        req = '0; rsp_ready = '0; req_t = '0; rsp_ready_t = '0;
        srt_done = 1'b0; srt_error = 1'b0; srt_sorted = '0; srt_positions = '0;
        for (int i = 0; i < N*V; i++) req_data[i*B +: B] = $urandom;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        chk("reset_to_gnt", W'(gnt_t), '0);
        chk("reset_to_valid", W'(rsp_valid_t), '0);
        reset = 1'b1;

        // Spurious sorter activity while idle must be ignored.
        srt_done = 1'b1;
        srt_error = 1'b1;
        srt_sorted = '1;
        @(negedge clk);
        srt_done = 1'b0;
        srt_error = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_zero("spurious");

        // Round robin with all four requesting: owners 0,1,2,3,0.
        req = 4'b1111;
        for (int j = 0; j < 5; j++)
            job($urandom_range(2, 12), 1'b0, 0, 1'b0, j == 4 ? 4'b0001 : 4'b1111, 1);

        // Single request with the small known vector and a 40-cycle sorter.
        req_data[0*B +: B] = 3;
        req_data[1*B +: B] = 1;
        req_data[2*B +: B] = 2;
        req_data[3*B +: B] = 0;
        job(40, 1'b0, 3, 1'b0, 4'b0011, 1);
        // Backpressure on requester 1, then requester 0 one edge after acceptance.
        job(10, 1'b0, 20, 1'b0, 4'b0011, 1);
        // Error together with done.
        job(7, 1'b1, 2, 1'b0, 4'b0000, 1);

        // Timeout with a silent sorter.
        req_t = 4'b0001;
        n = 0;
        while (srt_start_t !== 1'b1 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("to_start", W'(srt_start_t), W'(1));
        chk("to_gnt", W'(gnt_t), W'(4'b0001));
        n = 0;
        while (rsp_valid_t === '0 && n < TO + 8) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", W'(n), W'(TO + 1));
        chk("to_valid", W'(rsp_valid_t), W'(4'b0001));
        chk("to_status", W'(rsp_status_t), W'(2'b10));
        chk("to_sorted", rsp_sorted_t, '0);
        chk("to_positions", W'(rsp_positions_t), '0);
        rsp_ready_t = 4'b0001;
        req_t = '0;
        @(negedge clk);
        rsp_ready_t = '0;
        chk("to_accept", W'(rsp_valid_t), '0);

        // Reset while the main instance waits on the sorter.
        req = 4'b0010;
        repeat (5) @(negedge clk);
        chk("midwait_gnt", W'(gnt), W'(4'b0010));
        req = 4'b0110;
        #2 reset = 1'b0;
        #1 check_idle_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        req = 4'b0100;
        reset = 1'b1;
        rr = 0;
        job(5, 1'b0, 1, 1'b0, 4'b0000, 1);

        // Randomized jobs.
        m = N'($urandom_range(1, (1 << N) - 1));
        req = m;
        for (int j = 0; j < 12; j++) begin
            for (int i = 0; i < N*V; i++) req_data[i*B +: B] = $urandom;
            m = N'($urandom_range(1, (1 << N) - 1));
            job($urandom_range(1, 50), $urandom_range(0, 7) == 0, $urandom_range(0, 4),
                1'($urandom_range(0, 1)), j == 11 ? 4'b0000 : m, 1);
        end
        repeat (3) @(negedge clk);
        chk("final_gnt", W'(gnt), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
